multiword_addsub_seq: RTL and testbench

//   Sequential multi-word add/subtract unit wrapped around one sumator_32 instance.
//   - Accepts two operands of 32*NUM_WORDS bits through a valid/ready handshake.
//   - Walks them through the 32-bit adder one word per cycle, least significant word first, chaining the carry in a register.
//   - Returns the result plus carry/overflow/zero flags through a valid/ready handshake.
//   - Sits between operand fetch and writeback in the datapath; it is the sole client of its sumator_32.

---
 rtl/multiword_addsub_seq_if.sv | 29 ++
 rtl/multiword_addsub_seq.sv | 140 ++++++++++++++
 tb/tb_multiword_addsub_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/multiword_addsub_seq_if.sv
// Operand request / result response bundle for multiword_addsub_seq.
// The unit itself connects through the slave modport; the requester through master.
interface multiword_addsub_seq_if #(
  parameter int NUM_WORDS = 2
);
  localparam int DATA_W = 32 * NUM_WORDS;

  logic              in_valid;
  logic              in_ready;
  logic              op_sub;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              carry_out;
  logic              overflow;
  logic              zero;

  modport master (
    output in_valid, op_sub, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, op_sub, op_a, op_b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/multiword_addsub_seq.sv
// Sequential multi-word add/subtract around one 32-bit adder, LS word first.
// Optional build macro ADDSUB_SATURATE_EN clamps overflowing results to the signed extreme.
module sumator_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_s,
  output logic        o_cout
);
  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module multiword_addsub_seq #(
  parameter int NUM_WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multiword_addsub_seq_if.slave bus
);
  localparam int DATA_W = 32 * NUM_WORDS;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [NUM_WORDS-1:0][31:0] r_a;
  logic [NUM_WORDS-1:0][31:0] r_b;
  logic [NUM_WORDS-1:0][31:0] r_result;
  logic [NUM_WORDS-1:0][31:0] w_result_upd;
  logic [NUM_WORDS-1:0][31:0] w_result_fin;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_carry;
  logic                       r_carry_out;
  logic                       r_overflow;
  logic                       r_zero;
  logic [31:0]                w_a_word;
  logic [31:0]                w_b_word;
  logic [31:0]                w_sum;
  logic                       w_cout;
  logic                       w_last;
  logic                       w_accept;
  logic                       w_overflow;
  logic                       w_in_ready;

  assign w_in_ready = (r_state == S_IDLE) && rst_n;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_idx == LAST_IDX);

  always_comb begin
    w_a_word     = '0;
    w_b_word     = '0;
    w_result_upd = r_result;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_word        = r_a[i];
        w_b_word        = r_b[i];
        w_result_upd[i] = w_sum;
      end
    end
  end

  sumator_32 u_adder (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  // Only meaningful on the last word, where w_sum is the most significant word.
  assign w_overflow = (r_a[NUM_WORDS-1][31] == r_b[NUM_WORDS-1][31]) &&
                      (w_sum[31] != r_a[NUM_WORDS-1][31]);

`ifdef ADDSUB_SATURATE_EN
  function automatic logic [DATA_W-1:0] sat_extreme(input logic a_msb);
    return a_msb ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign w_result_fin = w_overflow ? sat_extreme(r_a[NUM_WORDS-1][31]) : w_result_upd;
`else
  assign w_result_fin = w_result_upd;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_next_state = S_CALC;
      S_CALC:  if (w_last)        w_next_state = S_DONE;
      S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        // Subtract is A + ~B + 1: the +1 rides in as the first carry-in.
        r_carry <= bus.op_sub;
        r_idx   <= '0;
      end else if (r_state == S_CALC) begin
        r_carry <= w_cout;
        if (w_last) begin
          r_result    <= w_result_fin;
          r_carry_out <= w_cout;
          r_overflow  <= w_overflow;
          r_zero      <= ~|w_result_fin;
        end else begin
          r_result <= w_result_upd;
          r_idx    <= r_idx + 1'b1;
        end
      end
    end
  end

  // Operand registers are pure data; they only matter after an accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.op_a;
      r_b <= bus.op_sub ? ~bus.op_b : bus.op_b;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Bench for multiword_addsub_seq: directed spec vectors plus random operations
// checked against an arithmetic reference model (NUM_WORDS 2, with 1 and 4 side instances).
module tb_multiword_addsub_seq;
  localparam int NW = 2;
  localparam int W  = 32 * NW;
  typedef logic [127:0] v_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multiword_addsub_seq_if #(.NUM_WORDS(NW)) bus  ();
  multiword_addsub_seq_if #(.NUM_WORDS(1))  bus1 ();
  multiword_addsub_seq_if #(.NUM_WORDS(4))  bus4 ();

  multiword_addsub_seq #(.NUM_WORDS(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multiword_addsub_seq #(.NUM_WORDS(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  multiword_addsub_seq #(.NUM_WORDS(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed and unsigned arithmetic on wider numbers.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic z);
    logic signed [W+1:0] exact, smax, smin;
    logic [W:0] u;
    smax = {3'b000, {(W-1){1'b1}}};
    smin = {3'b111, {(W-1){1'b0}}};
    if (sub) exact = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
    else     exact = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
    o = (exact > smax) || (exact < smin);
    u = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    c = sub ? (a >= b) : u[W];
    r = u[W-1:0];
`ifdef ADDSUB_SATURATE_EN
    if (o) r = exact[W+1] ? smin[W-1:0] : smax[W-1:0];
`endif
    z = (r == '0);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one operation and leave the DUT sitting in DONE; checks latency and outputs.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input string tag, output logic [W-1:0] r, output logic c,
                       output logic o, output logic z);
    logic [W-1:0] er;
    logic         ec, eo, ez;
    int           cyc;
    model(a, b, sub, er, ec, eo, ez);
    chk({tag, "_in_ready"}, v_t'(bus.in_ready), v_t'(1));
    bus.op_a = a; bus.op_b = b; bus.op_sub = sub; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op_a = {$urandom, $urandom}; bus.op_b = {$urandom, $urandom}; bus.op_sub = ~sub;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, v_t'(cyc), v_t'(NW));
    r = bus.result; c = bus.carry_out; o = bus.overflow; z = bus.zero;
    chk({tag, "_result"},   v_t'(r), v_t'(er));
    chk({tag, "_carry"},    v_t'(c), v_t'(ec));
    chk({tag, "_overflow"}, v_t'(o), v_t'(eo));
    chk({tag, "_zero"},     v_t'(z), v_t'(ez));
  endtask

  initial begin
    logic [W-1:0]   r, held_r, a, b;
    logic           c, o, z, sub;
    logic [2:0]     held_f, f1, f4;
    logic [31:0]    r1;
    logic [127:0]   r4;
    int             c1, c4;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1; bus.op_sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.op_sub = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1; bus4.op_sub = 1'b0; bus4.op_a = '0; bus4.op_b = '0;
    tick();
    tick();
    chk("rst_in_ready",  v_t'(bus.in_ready),  v_t'(0));
    chk("rst_out_valid", v_t'(bus.out_valid), v_t'(0));
    chk("rst_result",    v_t'(bus.result),    v_t'(0));
    chk("rst_flags",     v_t'({bus.carry_out, bus.overflow, bus.zero}), v_t'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", v_t'(bus.in_ready), v_t'(1));
    tick();

    do_op(64'h00000000_FFFFFFFF, 64'h1, 1'b0, "add_carry_chain", r, c, o, z);
    chk("add_carry_chain_const", v_t'({r, c, o, z}), v_t'({64'h00000001_00000000, 3'b000}));
    tick();
    chk("add_carry_chain_release", v_t'(bus.out_valid), v_t'(0));

    do_op(64'h0, 64'h1, 1'b1, "sub_borrow", r, c, o, z);
    chk("sub_borrow_const", v_t'({r, c, o, z}), v_t'({64'hFFFFFFFF_FFFFFFFF, 3'b000}));
    tick();

    do_op(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, "add_ovf", r, c, o, z);
`ifdef ADDSUB_SATURATE_EN
    chk("add_ovf_const", v_t'({r, c, o, z}), v_t'({64'h7FFFFFFF_FFFFFFFF, 3'b010}));
`else
    chk("add_ovf_const", v_t'({r, c, o, z}), v_t'({64'h80000000_00000000, 3'b010}));
`endif
    tick();

    do_op(64'h5, 64'h5, 1'b1, "sub_equal", r, c, o, z);
    chk("sub_equal_const", v_t'({r, c, o, z}), v_t'({64'h0, 3'b101}));
    tick();

    for (int k = 0; k < 16; k++) begin
      a = pick(); b = pick(); sub = 1'($urandom_range(0, 1));
      do_op(a, b, sub, "rand", r, c, o, z);
      tick();
      chk("rand_release", v_t'(bus.out_valid), v_t'(0));
    end

    // Back-pressure: result must hold while requests are ignored.
    bus.out_ready = 1'b0;
    do_op(pick(), pick(), 1'b0, "hold", held_r, c, o, z);
    held_f = {c, o, z};
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = ~k[0]; bus.op_a = {$urandom, $urandom}; bus.op_b = {$urandom, $urandom};
      tick();
      chk("hold_out_valid", v_t'(bus.out_valid), v_t'(1));
      chk("hold_in_ready",  v_t'(bus.in_ready),  v_t'(0));
      chk("hold_result",    v_t'(bus.result),    v_t'(held_r));
      chk("hold_flags",     v_t'({bus.carry_out, bus.overflow, bus.zero}), v_t'(held_f));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_single_delivery", v_t'(bus.out_valid), v_t'(0));
      tick();
    end

    // Reset one edge after accept drops the operation.
    bus.op_a = 64'h12345678_9ABCDEF0; bus.op_b = 64'h1; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready_low", v_t'(bus.in_ready), v_t'(0));
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", v_t'(bus.in_ready), v_t'(1));
    chk("midrst_result",   v_t'(bus.result),   v_t'(0));
    chk("midrst_flags",    v_t'({bus.carry_out, bus.overflow, bus.zero}), v_t'(0));
    for (int k = 0; k < 6; k++) begin
      chk("midrst_no_valid", v_t'(bus.out_valid), v_t'(0));
      tick();
    end

    // 5 - 5 on one-word and four-word instances.
    chk("nw1_in_ready", v_t'(bus1.in_ready), v_t'(1));
    chk("nw4_in_ready", v_t'(bus4.in_ready), v_t'(1));
    bus1.op_a = 32'd5;  bus1.op_b = 32'd5;  bus1.op_sub = 1'b1; bus1.in_valid = 1'b1;
    bus4.op_a = 128'd5; bus4.op_b = 128'd5; bus4.op_sub = 1'b1; bus4.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0; bus4.in_valid = 1'b0;
    bus1.op_a = $urandom; bus4.op_a = {4{$urandom}};
    c1 = 0; c4 = 0; r1 = '1; r4 = '1; f1 = '0; f4 = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus1.out_valid && c1 == 0) begin
        c1 = k; r1 = bus1.result; f1 = {bus1.carry_out, bus1.overflow, bus1.zero};
      end
      if (bus4.out_valid && c4 == 0) begin
        c4 = k; r4 = bus4.result; f4 = {bus4.carry_out, bus4.overflow, bus4.zero};
      end
    end
    chk("nw1_latency", v_t'(c1), v_t'(1));
    chk("nw1_result",  v_t'(r1), v_t'(0));
    chk("nw1_flags",   v_t'(f1), v_t'(3'b101));
    chk("nw4_latency", v_t'(c4), v_t'(4));
    chk("nw4_result",  v_t'(r4), v_t'(0));
    chk("nw4_flags",   v_t'(f4), v_t'(3'b101));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
